// File: rtl/regfile_pkg.sv
// regfile_pkg: shared width constants and typedefs for the register file and ALU-side modules
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2**ADDR_W;
   localparam int ZERO_REG = 0;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] idx_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: index decode, zero-register forcing, registered output; REGFILE_BYPASS_EN adds write-through
module regfile_read_port #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] read_reg,
   input  logic [DATA_W-1:0] regs [2**ADDR_W],
`ifdef REGFILE_BYPASS_EN
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
`endif
   output logic [DATA_W-1:0] read_data
);
   import regfile_pkg::*;
   logic [DATA_W-1:0] sel;
   // Index 0 wins over the bypass so a same-edge write to r0 still reads 0
   always_comb begin
      sel = (read_reg == ADDR_W'(ZERO_REG)) ? '0 :
`ifdef REGFILE_BYPASS_EN
            (reg_write && write_reg == read_reg) ? write_data :
`endif
            regs[read_reg];
   end
   always_ff @(posedge clk) begin
      if (rst) read_data <= '0;
      else if (rd_en) read_data <= sel;
   end
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 two-read/one-write register file with registered reads
// Define REGFILE_BYPASS_EN for write-through on same-edge read/write of one index.
module register_file #(
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              rd_valid,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data
);
   import regfile_pkg::*;
   localparam int NUM_REGS = 2**ADDR_W;
   logic [DATA_W-1:0] regs [NUM_REGS];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (reg_write && write_reg != ADDR_W'(ZERO_REG)) regs[write_reg] <= write_data;
         rd_valid <= rd_en;
      end
   end
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .read_reg  (read_reg1),
      .regs      (regs),
`ifdef REGFILE_BYPASS_EN
      .reg_write (reg_write),
      .write_reg (write_reg),
      .write_data(write_data),
`endif
      .read_data (read_data1)
   );
   regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .read_reg  (read_reg2),
      .regs      (regs),
`ifdef REGFILE_BYPASS_EN
      .reg_write (reg_write),
      .write_reg (write_reg),
      .write_data(write_data),
`endif
      .read_data (read_data2)
   );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file
module tb_register_file;
   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic [4:0]  read_reg1, read_reg2;
   logic [31:0] read_data1, read_data2;
   logic        rd_valid;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   int checks = 0;
   int failures = 0;

   register_file dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .read_reg1 (read_reg1),
      .read_reg2 (read_reg2),
      .read_data1(read_data1),
      .read_data2(read_data2),
      .rd_valid  (rd_valid),
      .reg_write (reg_write),
      .write_reg (write_reg),
      .write_data(write_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; rd_en = 1'b0; reg_write = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      idle(); reg_write = 1'b1; write_reg = a; write_data = d;
      tick();
      reg_write = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      idle(); rd_en = 1'b1; read_reg1 = a1; read_reg2 = a2;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_byp;
      rst = 1'b1; rd_en = 1'b0; reg_write = 1'b0;
      read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_data = '0;
      tick();
      chk("reset_rd1", read_data1, 32'h0);
      chk("reset_rd2", read_data2, 32'h0);
      chk("reset_valid", {31'b0, rd_valid}, 32'h0);
      // fill with junk, then reset with write/read requests that reset must override
      wr(5'd3, 32'hABCD_0123);
      wr(5'd31, 32'hFFFF_FFFF);
      wr(5'd17, 32'h1234_5678);
      rd(5'd3, 5'd31);
      chk("pre_rst_rd1", read_data1, 32'hABCD_0123);
      chk("pre_rst_rd2", read_data2, 32'hFFFF_FFFF);
      rst = 1'b1; rd_en = 1'b1; reg_write = 1'b1; write_reg = 5'd12; write_data = 32'h7777_7777;
      tick();
      chk("rst_valid", {31'b0, rd_valid}, 32'h0);
      chk("rst_rd1", read_data1, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i));
         chk($sformatf("clr_r%0d_p1", i), read_data1, 32'h0);
         chk($sformatf("clr_r%0d_p2", 31 - i), read_data2, 32'h0);
      end
      chk("clr_valid", {31'b0, rd_valid}, 32'h1);
      // basic write then read
      wr(5'd5, 32'h0000_00FF);
      rd(5'd5, 5'd0);
      chk("r5_p1", read_data1, 32'h0000_00FF);
      chk("r5_r0_p2", read_data2, 32'h0);
      chk("r5_valid", {31'b0, rd_valid}, 32'h1);
      // register 0 ignores writes
      wr(5'd0, 32'hDEAD_BEEF);
      rd(5'd0, 5'd0);
      chk("r0_p1", read_data1, 32'h0);
      chk("r0_p2", read_data2, 32'h0);
      idle(); reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hCAFE_F00D;
      rd_en = 1'b1; read_reg1 = 5'd0; read_reg2 = 5'd5;
      tick();
      chk("r0_same_edge_p1", read_data1, 32'h0);
      chk("r0_same_edge_p2", read_data2, 32'h0000_00FF);
      // same-edge write/read of reg 7
      wr(5'd7, 32'h1111_1111);
`ifdef REGFILE_BYPASS_EN
      exp_byp = 32'h2222_2222;
`else
      exp_byp = 32'h1111_1111;
`endif
      idle(); reg_write = 1'b1; write_reg = 5'd7; write_data = 32'h2222_2222;
      rd_en = 1'b1; read_reg1 = 5'd7; read_reg2 = 5'd7;
      tick();
      chk("r7_same_edge_p1", read_data1, exp_byp);
      chk("r7_same_edge_p2", read_data2, exp_byp);
      rd(5'd7, 5'd5);
      chk("r7_after_p1", read_data1, 32'h2222_2222);
      chk("r7_indep_p2", read_data2, 32'h0000_00FF);
      // back-to-back reads
      for (int i = 1; i <= 4; i++) wr(5'(i), 32'(i));
      idle(); rd_en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         read_reg1 = 5'(i); read_reg2 = 5'(5 - i);
         tick();
         chk($sformatf("b2b_%0d_p1", i), read_data1, 32'(i));
         chk($sformatf("b2b_%0d_p2", i), read_data2, 32'(5 - i));
         chk($sformatf("b2b_%0d_valid", i), {31'b0, rd_valid}, 32'h1);
      end
      rd_en = 1'b0; read_reg1 = 5'd7; read_reg2 = 5'd7;
      tick();
      chk("hold_p1", read_data1, 32'd4);
      chk("hold_p2", read_data2, 32'd1);
      chk("hold_valid", {31'b0, rd_valid}, 32'h0);
      tick();
      chk("hold2_p1", read_data1, 32'd4);
      // reset one cycle after a read drops data and valid
      wr(5'd9, 32'h5A5A_5A5A);
      rd(5'd9, 5'd9);
      chk("pre_drop_p1", read_data1, 32'h5A5A_5A5A);
      chk("pre_drop_valid", {31'b0, rd_valid}, 32'h1);
      rst = 1'b1; rd_en = 1'b1;
      tick();
      chk("drop_valid", {31'b0, rd_valid}, 32'h0);
      chk("drop_p1", read_data1, 32'h0);
      chk("drop_p2", read_data2, 32'h0);
      rd(5'd9, 5'd2);
      chk("post_rst_r9", read_data1, 32'h0);
      chk("post_rst_valid", {31'b0, rd_valid}, 32'h1);
      wr(5'd10, 32'h0BAD_F00D);
      rd(5'd10, 5'd10);
      chk("post_rst_r10_p1", read_data1, 32'h0BAD_F00D);
      chk("post_rst_r10_p2", read_data2, 32'h0BAD_F00D);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
